jpeg_bitstream_packer: RTL

Downstream stage of the Huffman encoder controller. It takes the per-symbol code/amplitude fields that the controller emits with each `jpeg_out_enable` pulse and packs them MSB-first into a continuous bitstream. It emits the stream as bytes, inserting a 0x00 stuff byte after every 0xFF, and pads with 1s to a byte boundary on flush. Its output feeds the JFIF writer.

---
 rtl/jpeg_bitstream_packer_if.sv | 34 +++
 rtl/jpeg_bitstream_packer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_packer_if.sv
// Symbol-field inputs from the Huffman controller and the byte stream toward the JFIF writer.
interface jpeg_bitstream_packer_if;
  logic        Huffmanenc_active;
  logic        jpeg_out_enable;
  logic [8:0]  jpeg_dc_out;
  logic [7:0]  jpeg_dc_out_length;
  logic [7:0]  jpeg_dc_code_list;
  logic [7:0]  jpeg_dc_code_size;
  logic [15:0] huffman_code;
  logic [7:0]  huffman_code_length;
  logic [7:0]  code_out;
  logic [7:0]  code_size_out;
  logic        flush_req;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        flush_done;
  logic        overflow;
  logic        protocol_err;
  logic        busy;

  modport master (
    output Huffmanenc_active, jpeg_out_enable, jpeg_dc_out, jpeg_dc_out_length,
           jpeg_dc_code_list, jpeg_dc_code_size, huffman_code, huffman_code_length,
           code_out, code_size_out, flush_req,
    input  byte_out, byte_valid, flush_done, overflow, protocol_err, busy
  );

  modport slave (
    input  Huffmanenc_active, jpeg_out_enable, jpeg_dc_out, jpeg_dc_out_length,
           jpeg_dc_code_list, jpeg_dc_code_size, huffman_code, huffman_code_length,
           code_out, code_size_out, flush_req,
    output byte_out, byte_valid, flush_done, overflow, protocol_err, busy
  );
endinterface

// File: rtl/jpeg_bitstream_packer.sv
// Packs DC/AC code and amplitude fields MSB-first into bytes, with 0xFF stuffing and 1-padding on flush.
module jpeg_bitstream_packer (
  input  logic                   clock,
  input  logic                   reset_n,
  jpeg_bitstream_packer_if.slave bus
);
  localparam int unsigned BUF_W = 64;
  localparam int unsigned CNT_W = 7;
  localparam logic [BUF_W-1:0] ALL_ONES = {BUF_W{1'b1}};

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_STUFF  = 3'd1;
  localparam logic [2:0] ST_FLUSH  = 3'd2;
  localparam logic [2:0] ST_FSTUFF = 3'd3;
  localparam logic [2:0] ST_FDONE  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [BUF_W-1:0] bit_buf, buf_nxt, fields;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt, cnt_d, app_len;
  logic             dc_pending, dc_nxt, active_q;
  logic [7:0]       byte_nxt, drained, sum;
  logic             valid_nxt, fdone_nxt, ovf_nxt, perr_nxt, busy_nxt;
  logic             drain, accept, flush_go;
  logic [2:0]       pad;
  logic [3:0]       dc_len, dc_sz, ac_sz;
  logic [4:0]       ac_len;

  assign dc_len = (bus.jpeg_dc_out_length > 8'd9)  ? 4'd9  : bus.jpeg_dc_out_length[3:0];
  assign dc_sz  = (bus.jpeg_dc_code_size > 8'd8)   ? 4'd8  : bus.jpeg_dc_code_size[3:0];
  assign ac_len = (bus.huffman_code_length > 8'd16) ? 5'd16 : bus.huffman_code_length[4:0];
  assign ac_sz  = (bus.code_size_out > 8'd8)       ? 4'd8  : bus.code_size_out[3:0];

  // Concatenate the masked fields of one symbol, oldest bit highest.
  always_comb begin
    fields  = '0;
    app_len = '0;
    if (dc_pending) begin
      fields  = BUF_W'(bus.jpeg_dc_out) & ~(ALL_ONES << dc_len);
      fields  = (fields << dc_sz) | (BUF_W'(bus.jpeg_dc_code_list) & ~(ALL_ONES << dc_sz));
      app_len = CNT_W'(dc_len) + CNT_W'(dc_sz);
    end
    fields  = (fields << ac_len) | (BUF_W'(bus.huffman_code) & ~(ALL_ONES << ac_len));
    fields  = (fields << ac_sz) | (BUF_W'(bus.code_out) & ~(ALL_ONES << ac_sz));
    app_len = app_len + CNT_W'(ac_len) + CNT_W'(ac_sz);
  end

  // Next state: drain on pre-edge count, then append, then flush padding.
  always_comb begin
    state_nxt = state;
    buf_nxt   = bit_buf;
    dc_nxt    = dc_pending;
    byte_nxt  = 8'h00;
    valid_nxt = 1'b0;
    fdone_nxt = 1'b0;
    ovf_nxt   = bus.overflow;
    perr_nxt  = bus.protocol_err;

    drain    = ((state == ST_RUN) || (state == ST_FLUSH)) && (bit_cnt >= CNT_W'(8));
    drained  = 8'(bit_buf >> (bit_cnt - CNT_W'(8)));
    cnt_d    = drain ? (bit_cnt - CNT_W'(8)) : bit_cnt;
    cnt_nxt  = cnt_d;
    accept   = bus.jpeg_out_enable && ((state == ST_RUN) || (state == ST_STUFF));
    sum      = 8'(cnt_d) + 8'(app_len);
    flush_go = (state == ST_RUN) && bus.flush_req;

    if (bus.jpeg_out_enable && !accept) perr_nxt = 1'b1;
    if (accept && (sum > 8'(BUF_W))) begin
      ovf_nxt = 1'b1;
    end else if (accept) begin
      buf_nxt = (bit_buf << app_len) | fields;
      cnt_nxt = sum[CNT_W-1:0];
      dc_nxt  = 1'b0;
    end

    pad = 3'd0 - cnt_nxt[2:0];
    if (flush_go) begin
      buf_nxt = (buf_nxt << pad) | ~(ALL_ONES << pad);
      cnt_nxt = cnt_nxt + CNT_W'(pad);
    end

    if (drain) begin
      valid_nxt = 1'b1;
      byte_nxt  = drained;
    end

    unique case (state)
      ST_RUN: begin
        if (drain && (drained == 8'hFF)) state_nxt = flush_go ? ST_FSTUFF : ST_STUFF;
        else if (flush_go)               state_nxt = ST_FLUSH;
      end
      ST_STUFF: begin
        valid_nxt = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        if (drain && (drained == 8'hFF)) begin
          state_nxt = ST_FSTUFF;
        end else if (bit_cnt == '0) begin
          state_nxt = ST_FDONE;
          fdone_nxt = 1'b1;
        end
      end
      ST_FSTUFF: begin
        valid_nxt = 1'b1;
        state_nxt = ST_FLUSH;
      end
      ST_FDONE: begin
        dc_nxt    = 1'b0;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase

    // A fresh controller run re-arms DC insertion even if this cycle cleared it.
    if (bus.Huffmanenc_active && !active_q) dc_nxt = 1'b1;
    busy_nxt = (cnt_nxt != '0) || (state_nxt != ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_RUN;
      bit_buf          <= '0;
      bit_cnt          <= '0;
      dc_pending       <= 1'b0;
      active_q         <= 1'b0;
      bus.byte_out     <= '0;
      bus.byte_valid   <= 1'b0;
      bus.flush_done   <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.protocol_err <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      state            <= state_nxt;
      bit_buf          <= buf_nxt;
      bit_cnt          <= cnt_nxt;
      dc_pending       <= dc_nxt;
      active_q         <= bus.Huffmanenc_active;
      bus.byte_out     <= byte_nxt;
      bus.byte_valid   <= valid_nxt;
      bus.flush_done   <= fdone_nxt;
      bus.overflow     <= ovf_nxt;
      bus.protocol_err <= perr_nxt;
      bus.busy         <= busy_nxt;
    end
  end
endmodule
